ov7670_dvp_source: RTL and testbench

- Synthesizable OV7670-compatible DVP transmitter. Emits vsync/href/8-bit data in RGB444 two-byte-per-pixel format, carrying selectable test patterns.
- Drives ov7670_capture and the frame buffer path in place of the real sensor, for board self-test and simulation.
- Single clock domain; one output byte per clk cycle. The downstream receiver samples on rising clk.

---
 rtl/ov7670_dvp_source.sv | 145 ++++++++++++++
 tb/tb_ov7670_dvp_source.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_dvp_source.sv
// OV7670-style DVP test-pattern source: vsync/href/8-bit RGB444 bytes, one byte per clk.
// Optional build macro DVP_SOURCE_FRAME_STAMP_EN puts frame_count into pixel (0,0) of each frame.
module ov7670_dvp_source #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  localparam int LP     = 2 * H_ACTIVE + H_BLANK;
  localparam int HC_W   = $clog2(LP);
  localparam int ML_A   = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int ML_B   = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
  localparam int MAX_L  = (ML_A > ML_B) ? ML_A : ML_B;
  localparam int VC_RAW = $clog2(MAX_L + 1);
  localparam int VC_W   = (VC_RAW > 5) ? VC_RAW : 5;
  localparam int XW     = (HC_W - 1 > 8) ? HC_W - 1 : 8;
  localparam int BAR_W  = H_ACTIVE / 8;

  localparam logic [HC_W-1:0] HC_LAST  = HC_W'(LP - 1);
  localparam logic [HC_W-1:0] HREF_END = HC_W'(2 * H_ACTIVE);
  localparam logic [VC_W-1:0] VFP_LAST = VC_W'(VFP_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBP    = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFP    = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [HC_W-1:0] hc, hc_n;
  logic [VC_W-1:0] vc, vc_n;
  logic [VC_W-1:0] region_last;
  logic [1:0]      pat_q;
  logic [11:0]     solid_q;

  logic            href_n;
  logic            done_n;
  logic [XW-1:0]   px_x;
  logic [4:0]      px_y;
  logic [2:0]      bar;
  logic [11:0]     rgb;
  logic [7:0]      byte_n;

  // Counters advance one byte per clk; region changes happen on the last byte of its last line.
  always_comb begin
    state_n     = state;
    hc_n        = hc;
    vc_n        = vc;
    region_last = '0;
    case (state)
      S_VSYNC:  region_last = VC_W'(VSYNC_LINES - 1);
      S_VBP:    region_last = VC_W'(VBP_LINES - 1);
      S_ACTIVE: region_last = VC_W'(V_ACTIVE - 1);
      S_VFP:    region_last = VFP_LAST;
      default:  region_last = '0;
    endcase
    if (state == S_IDLE) begin
      hc_n = '0;
      vc_n = '0;
      if (enable) state_n = S_VSYNC;
    end else if (hc == HC_LAST) begin
      hc_n = '0;
      if (vc == region_last) begin
        vc_n = '0;
        case (state)
          S_VSYNC:  state_n = S_VBP;
          S_VBP:    state_n = S_ACTIVE;
          S_ACTIVE: state_n = S_VFP;
          S_VFP:    state_n = enable ? S_VSYNC : S_IDLE;
          default:  state_n = S_IDLE;
        endcase
      end else begin
        vc_n = vc + 1'b1;
      end
    end else begin
      hc_n = hc + 1'b1;
    end
  end

  // Outputs are derived from the next-cycle position so they register in step with the FSM.
  always_comb begin
    href_n = (state_n == S_ACTIVE) && (hc_n < HREF_END);
    done_n = (state_n == S_VFP) && (vc_n == VFP_LAST) && (hc_n == HC_LAST);
    px_x   = XW'(hc_n >> 1);
    px_y   = vc_n[4:0];
    bar    = 3'(px_x / XW'(BAR_W));
    rgb    = 12'h000;
    case (pat_q)
      2'd0:    rgb = {bar[0] ? 4'hF : 4'h0, bar[1] ? 4'hF : 4'h0, bar[2] ? 4'hF : 4'h0};
      2'd1:    rgb = {px_x[3:0], px_y[3:0], px_x[7:4]};
      2'd2:    rgb = (px_x[4] ^ px_y[4]) ? 12'hFFF : 12'h000;
      default: rgb = solid_q;
    endcase
`ifdef DVP_SOURCE_FRAME_STAMP_EN
    if (px_x == '0 && px_y == '0 && vc_n == '0) rgb = {4'h0, frame_count};
`endif
    byte_n = hc_n[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      hc          <= '0;
      vc          <= '0;
      pat_q       <= 2'd0;
      solid_q     <= 12'h000;
      vsync       <= 1'b0;
      href        <= 1'b0;
      d           <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= 8'h00;
    end else begin
      state <= state_n;
      hc    <= hc_n;
      vc    <= vc_n;
      // Pattern settings are frozen for the whole frame once vsync ends.
      if (state == S_VSYNC && state_n == S_VBP) begin
        pat_q   <= pattern_sel;
        solid_q <= solid_rgb;
      end
      vsync      <= (state_n == S_VSYNC);
      href       <= href_n;
      d          <= href_n ? byte_n : 8'h00;
      frame_done <= done_n;
      if (done_n) frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ov7670_dvp_source.sv
// Bench for ov7670_dvp_source: frame-time reference model compared every cycle, plus literal timing/byte checks.
module tb_ov7670_dvp_source;

  localparam int HA    = 48;
  localparam int VA    = 34;
  localparam int HB    = 8;
  localparam int VSL   = 2;
  localparam int VBPL  = 3;
  localparam int VFPL  = 2;
  localparam int LP    = 2 * HA + HB;
  localparam int FRAME = (VSL + VBPL + VA + VFPL) * LP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [11:0] solid_rgb = 12'h000;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic        frame_done;
  logic [7:0]  frame_count;

  int n_total = 0;
  int n_pass  = 0;

  ov7670_dvp_source #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VSL), .VBP_LINES(VBPL), .VFP_LINES(VFPL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .vsync(vsync), .href(href), .d(d),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: position is just "cycles since frame start".
  logic        m_run = 1'b0;
  int          m_t = 0;
  logic [7:0]  m_cnt = 8'h00;
  logic [1:0]  m_pat = 2'd0;
  logic [11:0] m_solid = 12'h000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_t <= 0; m_cnt <= 8'h00; m_pat <= 2'd0; m_solid <= 12'h000;
    end else if (!m_run) begin
      if (enable) begin m_run <= 1'b1; m_t <= 0; end
    end else if (m_t == FRAME - 1) begin
      m_t <= 0;
      if (!enable) m_run <= 1'b0;
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == VSL * LP) begin m_pat <= pattern_sel; m_solid <= solid_rgb; end
      if (m_t + 1 == FRAME - 1) m_cnt <= m_cnt + 8'd1;
    end
  end

  function automatic logic [18:0] model_out();
    int line, h, x, y;
    logic [2:0] bar;
    logic [11:0] rgb;
    logic vs, hr, fd;
    logic [7:0] db;
    vs = 1'b0; hr = 1'b0; fd = 1'b0; db = 8'h00; rgb = 12'h000;
    if (m_run) begin
      line = m_t / LP;
      h    = m_t % LP;
      vs   = (line < VSL);
      fd   = (m_t == FRAME - 1);
      if (line >= VSL + VBPL && line < VSL + VBPL + VA && h < 2 * HA) begin
        hr  = 1'b1;
        x   = h / 2;
        y   = line - VSL - VBPL;
        bar = 3'(x / (HA / 8));
        case (m_pat)
          2'd0:    rgb = {bar[0] ? 4'hF : 4'h0, bar[1] ? 4'hF : 4'h0, bar[2] ? 4'hF : 4'h0};
          2'd1:    rgb = {x[3:0], y[3:0], x[7:4]};
          2'd2:    rgb = (x[4] ^ y[4]) ? 12'hFFF : 12'h000;
          default: rgb = m_solid;
        endcase
`ifdef DVP_SOURCE_FRAME_STAMP_EN
        if (x == 0 && y == 0) rgb = {4'h0, m_cnt};
`endif
        db = (h % 2 == 0) ? {4'h0, rgb[11:8]} : rgb[7:0];
      end
    end
    return {vs, hr, db, fd, m_cnt};
  endfunction

  // Scoreboard: every cycle the full output bundle must match the model.
  always @(negedge clk) begin
    check("stream", 32'({vsync, href, d, frame_done, frame_count}), 32'(model_out()));
  end

  // Monitor: measures timing features for the literal checks.
  int cyc = 0, vs_rises = 0, vs_rise_cyc = 0, vs_len = 0, period = 0;
  int first_href_delay = 0, hrefs_cur = 0, hi_cur = 0, run = 0;
  int min_run = 100000, max_run = 0, done_hrefs = 0, done_bytes = 0, done_count = 0;
  logic vs_prev = 1'b0, href_prev = 1'b0;
  logic [7:0] line0 [0:2*HA-1];

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    vs_prev   <= vsync;
    href_prev <= href;
    if (vsync && !vs_prev) begin
      if (vs_rises > 0) period <= cyc - vs_rise_cyc;
      vs_rises <= vs_rises + 1; vs_rise_cyc <= cyc; hrefs_cur <= 0; hi_cur <= 0;
    end
    if (!vsync && vs_prev) vs_len <= cyc - vs_rise_cyc;
    if (href && !href_prev) begin
      if (hrefs_cur == 0) begin first_href_delay <= cyc - vs_rise_cyc; line0[0] <= d; end
      hrefs_cur <= hrefs_cur + 1; run <= 1; hi_cur <= hi_cur + 1;
    end else if (href) begin
      if (hrefs_cur == 1 && run < 2 * HA) line0[run] <= d;
      run <= run + 1; hi_cur <= hi_cur + 1;
    end
    if (!href && href_prev) begin
      if (run < min_run) min_run <= run;
      if (run > max_run) max_run <= run;
    end
    if (frame_done) begin
      done_hrefs <= hrefs_cur; done_bytes <= hi_cur; done_count <= done_count + 1;
    end
  end

  // driver tasks
  task automatic wait_frame_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 2 * FRAME);
    check(tag, 32'(frame_done), 32'd1);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int rises_snap;

  initial begin
    #1 rst_n = 1'b0;
    wait_cycles(4);
    check("rst_vsync", 32'(vsync), 32'd0);
    check("rst_href", 32'(href), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    rst_n = 1'b1;
    wait_cycles(3);
    check("idle_vsync", 32'(vsync), 32'd0);

    // colour bars, continuous frames
    pattern_sel = 2'd0;
    enable = 1'b1;
    wait_cycles(1);
    check("vsync_rise_latency", 32'(vsync), 32'd1);
    wait_frame_done("frame0_done");
    check("vsync_len", 32'(vs_len), 32'(VSL * LP));
    check("first_href_delay", 32'(first_href_delay), 32'((VSL + VBPL) * LP));
    check("href_pulses", 32'(done_hrefs), 32'd34);
    check("bytes_per_frame", 32'(done_bytes), 32'd3264);
    check("href_min_len", 32'(min_run), 32'd96);
    check("href_max_len", 32'(max_run), 32'd96);
    check("bar0_b0", 32'(line0[0]), 32'h00);
    check("bar0_b1", 32'(line0[1]), 32'h00);
    check("bar1_b0", 32'(line0[12]), 32'h0F);
    check("bar1_b1", 32'(line0[13]), 32'h00);
    check("bar7_b0", 32'(line0[84]), 32'h0F);
    check("bar7_b1", 32'(line0[95]), 32'hFF);
    wait_frame_done("frame1_done");
    check("frame_period", 32'(period), 32'd4264);
    wait_frame_done("frame2_done");
    check("frame_count_3", 32'(frame_count), 32'd3);
    check("done_pulses_3", 32'(done_count), 32'd3);

    // random pattern / colour changes, including mid-frame
    for (int f = 0; f < 4; f++) begin
      pattern_sel = 2'(f);
      solid_rgb   = 12'($urandom);
      for (int k = 0; k < 3; k++) begin
        wait_cycles($urandom_range(300, 900));
        pattern_sel = 2'($urandom_range(0, 3));
        solid_rgb   = 12'($urandom);
      end
      wait_frame_done("rand_frame_done");
    end
    check("count_vs_pulses", 32'(frame_count), 32'(done_count[7:0]));

    // solid colour, changed mid-frame after latch
    pattern_sel = 2'd3;
    solid_rgb   = 12'hA5C;
    wait_cycles(1000);
    solid_rgb   = 12'h123;
    wait_frame_done("solid_frame_done");
    check("solid_b0", 32'(line0[0]), 32'h0A);
    check("solid_b1", 32'(line0[1]), 32'h5C);
    check("solid_last", 32'(line0[95]), 32'h5C);
    wait_frame_done("solid_next_done");
    check("solid_next_b0", 32'(line0[0]), 32'h01);
    check("solid_next_b1", 32'(line0[1]), 32'h23);

    // drop enable in active line 17; the frame must still complete
    wait_cycles(1 + (VSL + VBPL) * LP + 17 * LP + 30);
    enable = 1'b0;
    wait_frame_done("drop_frame_done");
    check("drop_href_pulses", 32'(done_hrefs), 32'd34);
    rises_snap = vs_rises;
    wait_cycles(30);
    check("drop_idle_vsync", 32'(vsync), 32'd0);
    check("drop_no_new_frame", 32'(vs_rises), 32'(rises_snap));

    // asynchronous reset in the middle of active line 3
    enable = 1'b1;
    wait_cycles(1 + (VSL + VBPL) * LP + 3 * LP + 40);
    check("pre_reset_href", 32'(href), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_vsync", 32'(vsync), 32'd0);
    check("arst_href", 32'(href), 32'd0);
    check("arst_d", 32'(d), 32'd0);
    check("arst_frame_count", 32'(frame_count), 32'd0);
    wait_cycles(3);
    enable = 1'b0;
    rst_n = 1'b1;
    wait_cycles(5);
    check("post_reset_idle", 32'(vsync), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
